// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, bit-period arithmetic and
// payload-width legality check. Used by uart_rx and uart_baud_cnt.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Clock cycles per serial bit, integer-truncated.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Payload widths the receiver supports.
    function automatic bit data_bits_ok(input int data_bits);
        return (data_bits >= 5) && (data_bits <= 8);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, held at 0 while
// restart_i is high. mid_o marks the bit centre, end_o the last cycle of a bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 1041
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic restart_i,
    output logic mid_o,
    output logic end_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: wrap at the end of a bit, clear on restart.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mid_o = (cnt_q == MID);
    assign end_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver: start, DATA_BITS LSB-first, optional even parity,
// one stop bit. Output is a valid/ready register with framing/overrun pulses.
// Build option: define UART_RX_PARITY_EN to add the parity bit and parity_err_o.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 10_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 uart_rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err_o
`endif
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    if (!data_bits_ok(DATA_BITS)) begin : g_bad_data_bits
        $error("uart_rx: DATA_BITS must be in 5..8");
    end

    logic                 sync1_q, rx_s_q, rx_d1_q, rx_d2_q;
    logic                 samp_q;
    logic                 mid_w;
    logic                 bit_end_unused;
    logic                 vote;
    rx_state_e            state_q, state_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 commit;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    // The counter free-runs from the start edge, so its mid strobe stays
    // centred on every following bit; the end strobe is not needed here.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .restart_i(state_q == ST_IDLE),
        .mid_o    (mid_w),
        .end_o    (bit_end_unused)
    );

    // Two-flop synchroniser plus two history taps for the majority vote.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d1_q <= 1'b1;
            rx_d2_q <= 1'b1;
            samp_q  <= 1'b0;
        end else begin
            sync1_q <= uart_rx_i;
            rx_s_q  <= sync1_q;
            rx_d1_q <= rx_s_q;
            rx_d2_q <= rx_d1_q;
            samp_q  <= mid_w;
        end
    end

    // One cycle after the mid strobe the taps hold samples at mid-1, mid, mid+1.
    assign vote = (rx_s_q & rx_d1_q) | (rx_s_q & rx_d2_q) | (rx_d1_q & rx_d2_q);

    // FSM next state, shift register, and output register next values.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        commit  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (rx_d1_q && !rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (samp_q) begin
                    if (vote) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (samp_q) begin
                    shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (samp_q) begin
                    if (vote != (^shreg_q)) begin
                        perr_d    = 1'b1;
                        par_bad_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (samp_q) begin
                    if (vote) begin
`ifdef UART_RX_PARITY_EN
                        commit = !par_bad_q;
`else
                        commit = 1'b1;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A full output slot that is not being drained drops the new frame.
        if (commit) begin
            if (valid_q && !ready_i) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end
        end
    end

    // FSM, shift register and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule
